// File: rtl/div_port_pkg.sv
// Shared encodings for the KCPSM6 port-mapped divider: FSM states,
// register offsets, CTRL/STATUS bit positions and the read-only ID value.
package div_port_pkg;

  // One-hot so the state bits drive the Qi/Qc/Qd LEDs directly
  typedef enum logic [2:0] {
    QI = 3'b001,
    QC = 3'b010,
    QD = 3'b100
  } div_state_t;

  localparam logic [1:0] OFS_X_QUO       = 2'd0;
  localparam logic [1:0] OFS_CTRL_STATUS = 2'd1;
  localparam logic [1:0] OFS_Y_REM       = 2'd2;
  localparam logic [1:0] OFS_ID          = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ACK   = 1;

  localparam logic [7:0] DIV_ID = 8'h44;

  function automatic logic [7:0] pack_status(input logic div_z, input logic qd,
                                             input logic qc, input logic qi,
                                             input logic done);
    return {3'b000, div_z, qd, qc, qi, done};
  endfunction

endpackage

// File: rtl/picoblaze_div_port_if.sv
// KCPSM6 port bus as seen between the processor (master) and a peripheral (slave).
interface picoblaze_div_port_if #(parameter int WIDTH = 8);

  logic [7:0]       port_id;
  logic [WIDTH-1:0] out_port;
  logic             write_strobe;
  logic             k_write_strobe;
  logic             read_strobe;
  logic [WIDTH-1:0] in_port;
  logic             interrupt;
  logic             interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );

endinterface

// File: rtl/div_sub_core.sv
// Repetitive-subtraction divider FSM (QI -> QC -> QD) with its datapath.
// Operands are latched on start so the input registers may change freely.
module div_sub_core
  import div_port_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             board_clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_z,
  output logic             qi,
  output logic             qc,
  output logic             qd,
  output logic             done,
  output logic             enter_done
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] divisor_q;

  always_ff @(posedge board_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= QI;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      QI:      if (start) state_d = (y == '0) ? QD : QC;
      QC:      if (remainder < divisor_q) state_d = QD;
      QD:      if (ack) state_d = QI;
      default: state_d = QI;
    endcase
  end

  always_comb begin
    qi         = (state_q == QI);
    qc         = (state_q == QC);
    qd         = (state_q == QD);
    done       = (state_q == QD);
    enter_done = (state_d == QD) && (state_q != QD);
  end

  // Divide-by-zero short-circuits to QD with an all-ones quotient
  always_ff @(posedge board_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_z     <= 1'b0;
    end else begin
      case (state_q)
        QI: begin
          if (start) begin
            divisor_q <= y;
            remainder <= x;
            div_z     <= (y == '0);
            quotient  <= (y == '0) ? '1 : '0;
          end
        end
        QC: begin
          if (remainder >= divisor_q) begin
            remainder <= remainder - divisor_q;
            quotient  <= quotient + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/picoblaze_div_port.sv
// Port-mapped divider peripheral for KCPSM6: address decode, operand
// registers, registered read mux and the completion interrupt.
module picoblaze_div_port
  import div_port_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [5:0] BASE_ADDR = 6'h00
) (
  input  logic                 board_clk,
  input  logic                 Reset_n,
  picoblaze_div_port_if.slave  bus,
  output logic                 Qi,
  output logic                 Qc,
  output logic                 Qd,
  output logic                 Done
);

  logic             hit;
  logic [1:0]       offset;
  logic             wr_en;
  logic             ctrl_wr;
  logic             start;
  logic             ack;
  logic             status_rd;
  logic             div_z;
  logic             enter_done;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] quotient, remainder;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    hit       = (bus.port_id[7:2] == BASE_ADDR);
    offset    = bus.port_id[1:0];
    wr_en     = hit && (bus.write_strobe || bus.k_write_strobe);
    ctrl_wr   = wr_en && (offset == OFS_CTRL_STATUS);
    start     = ctrl_wr && bus.out_port[CTRL_START];
    ack       = ctrl_wr && bus.out_port[CTRL_ACK];
    status_rd = hit && bus.read_strobe && (offset == OFS_CTRL_STATUS);
  end

  always_ff @(posedge board_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (wr_en) begin
      if (offset == OFS_X_QUO) x_q <= bus.out_port;
      if (offset == OFS_Y_REM) y_q <= bus.out_port;
    end
  end

  div_sub_core #(.WIDTH(WIDTH)) u_core (
    .board_clk  (board_clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .ack        (ack),
    .x          (x_q),
    .y          (y_q),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_z      (div_z),
    .qi         (Qi),
    .qc         (Qc),
    .qd         (Qd),
    .done       (Done),
    .enter_done (enter_done)
  );

  always_comb begin
    rd_data = '0;
    case (offset)
      OFS_X_QUO:       rd_data = quotient;
      OFS_CTRL_STATUS: rd_data = WIDTH'(pack_status(div_z, Qd, Qc, Qi, Done));
      OFS_Y_REM:       rd_data = remainder;
      OFS_ID:          rd_data = WIDTH'(DIV_ID);
      default:         rd_data = '0;
    endcase
  end

  // Registered every cycle regardless of read_strobe; KCPSM6 samples it on the second INPUT cycle
  always_ff @(posedge board_clk or negedge Reset_n) begin
    if (!Reset_n) bus.in_port <= '0;
    else          bus.in_port <= hit ? rd_data : '0;
  end

  always_ff @(posedge board_clk or negedge Reset_n) begin
    if (!Reset_n)                                        bus.interrupt <= 1'b0;
    else if (enter_done)                                 bus.interrupt <= 1'b1;
    else if (bus.interrupt_ack || status_rd || ack)      bus.interrupt <= 1'b0;
  end

endmodule

// File: tb/tb_picoblaze_div_port.sv
// Directed bench for picoblaze_div_port: drives the port bus like a KCPSM6
// and compares against hand-computed quotients, remainders and status bytes.
module tb_picoblaze_div_port;

  logic board_clk;
  logic Reset_n;
  logic Qi, Qc, Qd, Done;
  int   checks;
  int   failures;

  picoblaze_div_port_if bus ();

  picoblaze_div_port dut (
    .board_clk (board_clk),
    .Reset_n   (Reset_n),
    .bus       (bus),
    .Qi        (Qi),
    .Qc        (Qc),
    .Qd        (Qd),
    .Done      (Done)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle OUTPUT (or OUTPUTK when use_k is set); returns at the negedge after the sampling edge
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data, input logic use_k);
    @(negedge board_clk);
    bus.port_id        = addr;
    bus.out_port       = data;
    bus.write_strobe   = !use_k;
    bus.k_write_strobe = use_k;
    @(posedge board_clk);
    @(negedge board_clk);
    bus.write_strobe   = 1'b0;
    bus.k_write_strobe = 1'b0;
  endtask

  task automatic readPort(input logic [7:0] addr, output logic [7:0] data);
    @(negedge board_clk);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    @(posedge board_clk);
    @(negedge board_clk);
    bus.read_strobe = 1'b0;
    data = bus.in_port;
  endtask

  // Cycle count includes the edge that sampled the Start write
  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!Done && cycles < 400) begin
      @(negedge board_clk);
      cycles++;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         cycles;
    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    bus.port_id        = 8'h00;
    bus.out_port       = 8'h00;
    bus.write_strobe   = 1'b0;
    bus.k_write_strobe = 1'b0;
    bus.read_strobe    = 1'b0;
    bus.interrupt_ack  = 1'b0;
    repeat (2) @(negedge board_clk);
    checkOutput("reset_flags", {4'b0, Qd, Qc, Qi, Done}, 8'h02);
    checkOutput("reset_irq", {7'b0, bus.interrupt}, 8'h00);
    checkOutput("reset_in_port", bus.in_port, 8'h00);
    Reset_n = 1'b1;
    readPort(8'h01, rd);
    checkOutput("reset_status", rd, 8'h02);

    $display("[TB] test 1: 100 / 7");
    applyStimulus(8'h00, 8'd100, 1'b0);
    applyStimulus(8'h02, 8'd7, 1'b1);
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone(cycles);
    checkOutput("t1_latency", 8'(cycles), 8'd16);
    checkOutput("t1_irq_set", {7'b0, bus.interrupt}, 8'h01);
    readPort(8'h00, rd);
    checkOutput("t1_quotient", rd, 8'd14);
    readPort(8'h02, rd);
    checkOutput("t1_remainder", rd, 8'd2);
    checkOutput("t1_irq_hold", {7'b0, bus.interrupt}, 8'h01);
    readPort(8'h01, rd);
    checkOutput("t1_status", rd, 8'h09);
    checkOutput("t1_irq_status_clr", {7'b0, bus.interrupt}, 8'h00);
    applyStimulus(8'h01, 8'h02, 1'b0);
    checkOutput("t1_ack_flags", {4'b0, Qd, Qc, Qi, Done}, 8'h02);

    $display("[TB] test 2: 5 / 9");
    applyStimulus(8'h00, 8'd5, 1'b1);
    applyStimulus(8'h02, 8'd9, 1'b1);
    applyStimulus(8'h01, 8'h01, 1'b1);
    checkOutput("t2_in_qc", {7'b0, Qc}, 8'h01);
    waitDone(cycles);
    checkOutput("t2_latency", 8'(cycles), 8'd2);
    readPort(8'h00, rd);
    checkOutput("t2_quotient", rd, 8'd0);
    readPort(8'h02, rd);
    checkOutput("t2_remainder", rd, 8'd5);
    checkOutput("t2_irq_set", {7'b0, bus.interrupt}, 8'h01);
    applyStimulus(8'h01, 8'h02, 1'b1);
    checkOutput("t2_irq_ack_clr", {7'b0, bus.interrupt}, 8'h00);
    readPort(8'h01, rd);
    checkOutput("t2_status", rd, 8'h02);
    checkOutput("t2_done", {7'b0, Done}, 8'h00);

    $display("[TB] test 3: divide by zero");
    applyStimulus(8'h02, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h3C, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    checkOutput("t3_in_qd", {7'b0, Qd}, 8'h01);
    readPort(8'h00, rd);
    checkOutput("t3_quotient", rd, 8'hFF);
    readPort(8'h02, rd);
    checkOutput("t3_remainder", rd, 8'h3C);
    checkOutput("t3_irq_set", {7'b0, bus.interrupt}, 8'h01);
    @(negedge board_clk);
    bus.interrupt_ack = 1'b1;
    @(negedge board_clk);
    bus.interrupt_ack = 1'b0;
    checkOutput("t3_irq_intack_clr", {7'b0, bus.interrupt}, 8'h00);
    readPort(8'h01, rd);
    checkOutput("t3_status", rd, 8'h19);
    applyStimulus(8'h01, 8'h02, 1'b0);

    $display("[TB] test 4: writes during compute, start+ack in done");
    applyStimulus(8'h00, 8'd200, 1'b0);
    applyStimulus(8'h02, 8'd3, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    applyStimulus(8'h00, 8'd1, 1'b0);
    applyStimulus(8'h02, 8'd1, 1'b0);
    checkOutput("t4_still_qc", {7'b0, Qc}, 8'h01);
    waitDone(cycles);
    checkOutput("t4_done", {7'b0, Done}, 8'h01);
    readPort(8'h00, rd);
    checkOutput("t4_quotient", rd, 8'd66);
    readPort(8'h02, rd);
    checkOutput("t4_remainder", rd, 8'd2);
    applyStimulus(8'h01, 8'h03, 1'b0);
    repeat (3) @(negedge board_clk);
    readPort(8'h01, rd);
    checkOutput("t4_no_restart", rd, 8'h02);
    readPort(8'h00, rd);
    checkOutput("t4_result_held", rd, 8'd66);

    $display("[TB] test 5: reset during compute");
    applyStimulus(8'h00, 8'd250, 1'b0);
    applyStimulus(8'h02, 8'd1, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    repeat (5) @(negedge board_clk);
    bus.port_id = 8'h01;
    @(negedge board_clk);
    checkOutput("t5_pre_reset_qc", {7'b0, Qc}, 8'h01);
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("t5_reset_flags", {4'b0, Qd, Qc, Qi, Done}, 8'h02);
    checkOutput("t5_reset_in_port", bus.in_port, 8'h00);
    checkOutput("t5_reset_irq", {7'b0, bus.interrupt}, 8'h00);
    @(negedge board_clk);
    Reset_n = 1'b1;
    readPort(8'h00, rd);
    checkOutput("t5_quotient_cleared", rd, 8'h00);
    applyStimulus(8'h00, 8'd9, 1'b0);
    applyStimulus(8'h02, 8'd4, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone(cycles);
    checkOutput("t5_latency", 8'(cycles), 8'd4);
    readPort(8'h00, rd);
    checkOutput("t5_quotient", rd, 8'd2);
    readPort(8'h02, rd);
    checkOutput("t5_remainder", rd, 8'd1);
    applyStimulus(8'h01, 8'h02, 1'b0);

    $display("[TB] test 6: ID and address decode");
    readPort(8'h03, rd);
    checkOutput("t6_id", rd, 8'h44);
    applyStimulus(8'h10, 8'hAA, 1'b0);
    applyStimulus(8'h12, 8'h01, 1'b0);
    applyStimulus(8'h11, 8'h01, 1'b0);
    applyStimulus(8'h03, 8'h01, 1'b0);
    checkOutput("t6_miss_no_start", {4'b0, Qd, Qc, Qi, Done}, 8'h02);
    readPort(8'h11, rd);
    checkOutput("t6_miss_read", rd, 8'h00);
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone(cycles);
    readPort(8'h00, rd);
    checkOutput("t6_quotient_kept_xy", rd, 8'd2);
    readPort(8'h02, rd);
    checkOutput("t6_remainder_kept_xy", rd, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
